// File: rtl/sg_sched_pkg.sv
// Shared register map, bit indices and FSM state encoding for sg_frame_scheduler.
package sg_sched_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_FSEL   = 4'h4;
    localparam logic [3:0] OFF_FRAMES = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_CONT   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_CNT_LSB = 16;

    localparam int unsigned LOAD_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

    // A programmed frame count of zero behaves as a single frame.
    function automatic logic [15:0] frames_eff(input logic [15:0] f);
        return (f == 16'd0) ? 16'd1 : f;
    endfunction

endpackage

// File: rtl/sg_fsel_serializer.sv
// Shifts the 4-bit frequency select out MSB first over the LOAD_CYCLES load window.
module sg_fsel_serializer
    import sg_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       abort_i,
    input  logic [3:0] fsel_i,
    output logic       serial_o,
    output logic       load_o,
    output logic       last_o
);

    logic [3:0] shift_q;
    logic [1:0] cnt_q;
    logic       active_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            shift_q  <= fsel_i;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            // zero fill leaves the serial line low once all four bits are out
            shift_q <= {shift_q[2:0], 1'b0};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'(LOAD_CYCLES - 1)) begin
                active_q <= 1'b0;
            end
        end
    end

    assign serial_o = shift_q[3];
    assign load_o   = active_q;
    assign last_o   = active_q && (cnt_q == 2'(LOAD_CYCLES - 1));

endmodule

// File: rtl/sg_frame_scheduler.sv
// Wishbone-controlled frame scheduler for a signal generator.
// Optional registered completion interrupt: define SG_SCHED_IRQ_EN.
module sg_frame_scheduler
    import sg_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter logic [15:0] FRAMES_DEF = 16'd1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        sg_enable_o,
    output logic        sg_fsel_serial_o,
    output logic        sg_load_config_o,
    input  logic        sg_phi_p_i,
    output logic        irq_o
);

    logic        ack_q;
    logic [31:0] dat_q;
    logic        cont_q;
    logic        irq_en;
    logic [3:0]  fsel_q;
    logic [15:0] frames_q;

    sched_state_e state_q;
    logic         enable_q;
    logic         busy_q;
    logic         done_q;
    logic [15:0]  cnt_q;
    logic [15:0]  frames_sh_q;
    logic         settle_q;
    logic         phi_prev_q;

    logic [31:0] offset;
    logic [3:0]  off;
    logic        mapped;
    logic        accept;
    logic        wr;
    logic        start_wr;
    logic        abort_wr;
    logic        done_clr;
    logic        ser_load;
    logic        ser_last;
    logic        rise;
    logic [15:0] cnt_inc;
    logic [31:0] rdata_d;
    logic        unused_bits;

    assign offset   = wbs_adr_i - BASE_ADDR;
    assign off      = offset[3:0];
    assign mapped   = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
    // Accepting only when ack is low spaces acks out even under a held strobe.
    assign accept   = wbs_stb_i && wbs_cyc_i && mapped && !ack_q;
    assign wr       = accept && wbs_we_i;
    assign abort_wr = wr && (off == OFF_CTRL) && wbs_dat_i[CTRL_ABORT];
    assign start_wr = wr && (off == OFF_CTRL) && wbs_dat_i[CTRL_START] && !wbs_dat_i[CTRL_ABORT];
    assign done_clr = wr && (off == OFF_STATUS) && wbs_dat_i[STAT_DONE];
    assign ser_load = start_wr && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign rise     = (state_q == ST_RUN) && sg_phi_p_i && !phi_prev_q;
    assign cnt_inc  = cnt_q + 16'd1;

    assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:16]};

    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_CTRL: begin
                rdata_d[CTRL_CONT]   = cont_q;
                rdata_d[CTRL_IRQ_EN] = irq_en;
            end
            OFF_FSEL:   rdata_d[3:0]  = fsel_q;
            OFF_FRAMES: rdata_d[15:0] = frames_q;
            OFF_STATUS: begin
                rdata_d[STAT_BUSY]                   = busy_q;
                rdata_d[STAT_DONE]                   = done_q;
                rdata_d[STAT_CNT_LSB +: 16]          = cnt_q;
            end
            default: rdata_d = '0;
        endcase
    end

`ifdef SG_SCHED_IRQ_EN
    logic irq_en_q;
    logic irq_q;
    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && (off == OFF_CTRL)) begin
                irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
            end
            irq_q <= done_q && irq_en_q;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            cont_q   <= 1'b0;
            fsel_q   <= '0;
            frames_q <= FRAMES_DEF;
        end else begin
            ack_q <= accept;
            if (accept && !wbs_we_i) begin
                dat_q <= rdata_d;
            end
            if (wr) begin
                case (off)
                    OFF_CTRL:   cont_q   <= wbs_dat_i[CTRL_CONT];
                    OFF_FSEL:   fsel_q   <= wbs_dat_i[3:0];
                    OFF_FRAMES: frames_q <= wbs_dat_i[15:0];
                    default:    ;
                endcase
            end
        end
    end

    sg_fsel_serializer u_ser (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .load_i   (ser_load),
        .abort_i  (abort_wr),
        .fsel_i   (fsel_q),
        .serial_o (sg_fsel_serial_o),
        .load_o   (sg_load_config_o),
        .last_o   (ser_last)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            frames_sh_q <= 16'd1;
            settle_q    <= 1'b0;
            phi_prev_q  <= 1'b1;
        end else begin
            phi_prev_q <= (state_q == ST_RUN) ? sg_phi_p_i : 1'b1;
            // A clear is overridden by any set assigned later in this block.
            if (done_clr) begin
                done_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ser_load) begin
                        state_q     <= ST_LOAD;
                        enable_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        frames_sh_q <= frames_eff(frames_q);
                    end else begin
                        state_q  <= ST_IDLE;
                        enable_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort_wr) begin
                        state_q  <= ST_IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (ser_last) begin
                        state_q  <= ST_SETTLE;
                        settle_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort_wr) begin
                        state_q  <= ST_IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (settle_q) begin
                        state_q <= ST_RUN;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort_wr) begin
                        state_q  <= ST_IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (rise) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == frames_sh_q) begin
                            done_q <= 1'b1;
                            if (!cont_q) begin
                                state_q  <= ST_DONE;
                                enable_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign sg_enable_o = enable_q;

endmodule

// File: tb/tb_sg_frame_scheduler.sv
// Directed self-checking bench for sg_frame_scheduler; honours SG_SCHED_IRQ_EN.
module tb_sg_frame_scheduler;

    localparam logic [31:0] BASE     = 32'h3000_0100;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_FSEL   = BASE + 32'h4;
    localparam logic [31:0] A_FRAMES = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

`ifdef SG_SCHED_IRQ_EN
    localparam logic [31:0] EXP_IRQ   = 32'd1;
    localparam logic [31:0] EXP_CTRL8 = 32'h8;
`else
    localparam logic [31:0] EXP_IRQ   = 32'd0;
    localparam logic [31:0] EXP_CTRL8 = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        en;
    logic        ser;
    logic        ld;
    logic        phi = 1'b0;
    logic        irq;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] rd_v;

    always #5 clk = ~clk;

    sg_frame_scheduler #(
        .BASE_ADDR  (32'h3000_0100),
        .FRAMES_DEF (16'd1)
    ) dut (
        .wb_clk_i         (wb_clk_unused_guard(clk)),
        .wb_rst_i         (rst),
        .wbs_stb_i        (stb),
        .wbs_cyc_i        (cyc),
        .wbs_we_i         (we),
        .wbs_sel_i        (sel),
        .wbs_adr_i        (adr),
        .wbs_dat_i        (wdat),
        .wbs_ack_o        (ack),
        .wbs_dat_o        (rdat),
        .sg_enable_o      (en),
        .sg_fsel_serial_o (ser),
        .sg_load_config_o (ld),
        .sg_phi_p_i       (phi),
        .irq_o            (irq)
    );

    function automatic logic wb_clk_unused_guard(input logic c);
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r);
        logic got;
        got  = 1'b0;
        stb  = 1'b1;
        cyc  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (ack) got = 1'b1;
        end
        r   = rdat;
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        check("ack", 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'h0, r);
        check(tag, r, exp);
    endtask

    task automatic pulse();
        phi = 1'b1;
        tick();
        phi = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int unsigned acks;
        int unsigned consec;
        logic        prev_ack;

        ticks(3);
        rst = 1'b0;
        tick();
        check("rst_en",   32'(en),  32'd0);
        check("rst_ld",   32'(ld),  32'd0);
        check("rst_ser",  32'(ser), 32'd0);
        check("rst_irq",  32'(irq), 32'd0);
        check("rst_ack",  32'(ack), 32'd0);
        check("rst_dat",  rdat,     32'd0);
        rd_chk("rst_ctrl",   A_CTRL,   32'h0);
        rd_chk("rst_fsel",   A_FSEL,   32'h0);
        rd_chk("rst_frames", A_FRAMES, 32'h1);
        rd_chk("rst_status", A_STATUS, 32'h0);

        // serial load of 4'b1010
        wr(A_FSEL, 32'hA);
        wr(A_FRAMES, 32'h2);
        check("pre_en", 32'(en), 32'd0);
        wr(A_CTRL, 32'h1);
        check("ld0_en",  32'(en),  32'd1);
        check("ld0_ld",  32'(ld),  32'd1);
        check("ld0_ser", 32'(ser), 32'd1);
        tick();
        check("ld1_ld",  32'(ld),  32'd1);
        check("ld1_ser", 32'(ser), 32'd0);
        tick();
        check("ld2_ser", 32'(ser), 32'd1);
        tick();
        check("ld3_ld",  32'(ld),  32'd1);
        check("ld3_ser", 32'(ser), 32'd0);
        tick();
        check("st_ld",  32'(ld), 32'd0);
        check("st_en",  32'(en), 32'd1);
        wr(A_CTRL, 32'h2);
        check("abort_ld_en", 32'(en), 32'd0);
        rd_chk("abort_ld_status", A_STATUS, 32'h0);

        // three frames to completion
        wr(A_FRAMES, 32'h3);
        wr(A_CTRL, 32'h1);
        ticks(7);
        pulse();
        pulse();
        check("f3_en_mid", 32'(en), 32'd1);
        phi = 1'b1;
        tick();
        check("f3_en_low", 32'(en), 32'd0);
        phi = 1'b0;
        tick();
        rd_chk("f3_status", A_STATUS, 32'h0003_0002);
        wr(A_STATUS, 32'h2);
        rd_chk("f3_w1c", A_STATUS, 32'h0003_0000);

        // phi high across enable is not a frame
        wr(A_FRAMES, 32'h1);
        phi = 1'b1;
        wr(A_CTRL, 32'h1);
        ticks(16);
        phi = 1'b0;
        ticks(3);
        rd_chk("lvl_status", A_STATUS, 32'h0000_0001);
        check("lvl_en", 32'(en), 32'd1);
        pulse();
        tick();
        rd_chk("lvl_done", A_STATUS, 32'h0001_0002);
        wr(A_STATUS, 32'h2);

        // abort mid-run
        wr(A_FRAMES, 32'h5);
        wr(A_CTRL, 32'h1);
        ticks(7);
        pulse();
        wr(A_CTRL, 32'h2);
        check("abort_en", 32'(en), 32'd0);
        rd_chk("abort_status", A_STATUS, 32'h0001_0000);

        // start and writes while busy
        wr(A_FRAMES, 32'h2);
        wr(A_CTRL, 32'h1);
        ticks(7);
        pulse();
        wr(A_CTRL, 32'h1);
        rd_chk("busy_start", A_STATUS, 32'h0001_0001);
        wr(A_FRAMES, 32'h7);
        pulse();
        tick();
        rd_chk("busy_done", A_STATUS, 32'h0002_0002);
        rd_chk("busy_frames", A_FRAMES, 32'h7);
        wr(A_STATUS, 32'h2);

        // FRAMES=0 behaves as 1
        wr(A_FRAMES, 32'h0);
        wr(A_CTRL, 32'h1);
        ticks(7);
        pulse();
        tick();
        rd_chk("f0_status", A_STATUS, 32'h0001_0002);
        wr(A_STATUS, 32'h2);

        // continuous mode; set beats W1C on the same cycle
        wr(A_FRAMES, 32'h2);
        wr(A_CTRL, 32'h5);
        ticks(7);
        pulse();
        tick();
        phi = 1'b1;
        wr(A_STATUS, 32'h2);
        phi = 1'b0;
        rd_chk("cont_setwins", A_STATUS, 32'h0002_0003);
        check("cont_en", 32'(en), 32'd1);
        wr(A_STATUS, 32'h2);
        rd_chk("cont_clr", A_STATUS, 32'h0002_0001);
        wr(A_CTRL, 32'h2);
        check("cont_abort_en", 32'(en), 32'd0);
        rd_chk("cont_abort", A_STATUS, 32'h0002_0000);

        // interrupt
        wr(A_FRAMES, 32'h1);
        wr(A_CTRL, 32'h8);
        rd_chk("ctrl_irqen", A_CTRL, EXP_CTRL8);
        wr(A_CTRL, 32'h9);
        ticks(7);
        pulse();
        tick();
        check("irq_set", 32'(irq), EXP_IRQ);
        ticks(3);
        check("irq_hold", 32'(irq), EXP_IRQ);
        wr(A_STATUS, 32'h2);
        tick();
        check("irq_clr", 32'(irq), 32'd0);

        // abort wins over start in one write
        wr(A_CTRL, 32'h3);
        tick();
        check("ab_st_en", 32'(en), 32'd0);
        rd_chk("ab_st_status", A_STATUS, 32'h0001_0000);

        // unmapped address
        stb = 1'b1;
        cyc = 1'b1;
        adr = BASE + 32'h10;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack) acks++;
        end
        stb = 1'b0;
        cyc = 1'b0;
        check("unmapped_ack", 32'(acks), 32'd0);

        // held strobe on STATUS
        tick();
        stb      = 1'b1;
        cyc      = 1'b1;
        adr      = A_STATUS;
        acks     = 0;
        consec   = 0;
        prev_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack) acks++;
            if (ack && prev_ack) consec++;
            prev_ack = ack;
        end
        stb = 1'b0;
        cyc = 1'b0;
        check("b2b_acks",   32'(acks),   32'd4);
        check("b2b_consec", 32'(consec), 32'd0);
        check("b2b_dat",    rdat,        32'h0001_0000);
        tick();

        // reset during RUN
        wr(A_FRAMES, 32'h2);
        wr(A_CTRL, 32'h1);
        ticks(7);
        check("rr_en_before", 32'(en), 32'd1);
        rst = 1'b1;
        tick();
        check("rr_en_after", 32'(en), 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("rr_status", A_STATUS, 32'h0);
        rd_chk("rr_frames", A_FRAMES, 32'h1);
        xfer(1'b0, A_FSEL, 32'h0, rd_v);
        check("rr_fsel", rd_v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sg_frame_scheduler.md
SG_FRAME_SCHEDULER -- requirements
Module: sg_frame_scheduler

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0100: Wishbone base address of the four-word register window.
REQ-002 SHALL have parameter FRAMES_DEF, default 16'd1: FRAMES register reset value.
REQ-003 SHALL have port wb_clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i (input, 1), wbs_sel_i (input, 4), wbs_adr_i and wbs_dat_i (input, 32): Wishbone slave request.
REQ-006 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32): Wishbone slave response.
REQ-007 SHALL have port sg_enable_o, output, 1: enable to the signal generator.
REQ-008 SHALL have ports sg_fsel_serial_o and sg_load_config_o, output, 1: serial frequency-select data and its shift strobe.
REQ-009 SHALL have port sg_phi_p_i, input, 1: generator phi_p, synchronous to wb_clk_i.
REQ-010 SHALL have port irq_o, output, 1: frame-batch-complete interrupt.

Function
REQ-011 Register map, offsets from BASE_ADDR:
- 0x0 CTRL: bit0 START (self-clearing), bit1 ABORT (self-clearing), bit2 CONT (continuous), bit3 IRQ_EN.
- 0x4 FSEL: bits[3:0].
- 0x8 FRAMES: bits[15:0].
- 0xC STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear), bits[31:16] frames completed (RO).
REQ-012 Bus handshake:
- wbs_ack_o pulses one cycle after stb&cyc to a mapped address, never on two consecutive cycles.
- Unmapped address: no ack.
- Reads return zero in unused bits.
- wbs_sel_i is ignored (full-word access).
REQ-013 FSM states: IDLE, LOAD, SETTLE, RUN, DONE.
REQ-014 IDLE: all sg outputs low. START moves to LOAD, latches FSEL and FRAMES into shadow copies (FRAMES=0 treated as 1), clears the frame counter, sets BUSY.
REQ-015 LOAD: exactly 4 cycles.
- sg_enable_o=1, sg_load_config_o=1.
- sg_fsel_serial_o carries shadow FSEL MSB first, bit3 on cycle 0 through bit0 on cycle 3.
REQ-016 SETTLE: 2 cycles, sg_enable_o=1, load and serial low; then to RUN.
REQ-017 RUN: sg_enable_o=1.
- A rising edge of sg_phi_p_i (1 now, 0 on the previous cycle) increments the 16-bit frame counter.
- The edge register is forced to 1 outside RUN, so the enable-time high level is not counted.
REQ-018 RUN exit: when the counter reaches shadow FRAMES and CONT=0, go to DONE on the next cycle. With CONT=1, the counter wraps 0xFFFF->0 and RUN continues, setting DONE on each shadow-FRAMES match.
REQ-019 DONE: sg_enable_o=0, BUSY=0, DONE=1; back to IDLE after 1 cycle; the counter holds its value.
REQ-020 ABORT in LOAD, SETTLE or RUN: IDLE next cycle, enable drops, DONE stays unset. ABORT in the same write as START: ABORT wins.
REQ-021 START while BUSY is ignored. FSEL/FRAMES writes while BUSY update the registers but not the shadows.
REQ-022 A rising phi_p edge on the same cycle a W1C write clears DONE: the set wins.

Reset
REQ-023 wb_rst_i sets:
- state = IDLE; all sg outputs, irq_o, wbs_ack_o = 0; wbs_dat_o = 0.
- CTRL = 0, FSEL = 0, FRAMES = FRAMES_DEF; counter, BUSY, DONE = 0.
REQ-024 Reset mid-RUN takes effect next cycle and drops sg_enable_o immediately.

Configuration
REQ-025 With SG_SCHED_IRQ_EN defined: irq_o = DONE & IRQ_EN, registered.
REQ-026 Without it: irq_o tied 0, IRQ_EN reads 0.

Structure
REQ-027 Package sg_sched_pkg holds the register offsets, CTRL/STATUS bit indices, and the state encoding constants.
REQ-028 Sub-module sg_fsel_serializer holds the 4-bit MSB-first shifter and LOAD cycle counter.

Verification
REQ-029 FSEL=4'b1010, FRAMES=2, START -> LOAD: serial 1,0,1,0 with load=1 for 4 cycles; enable high from the first LOAD cycle.
REQ-030 FRAMES=3, three phi_p rising edges -> DONE=1, BUSY=0, STATUS[31:16]=3, enable low one cycle after the third edge.
REQ-031 phi_p held high from enable until 10 cycles into RUN, then low -> counter stays 0.
REQ-032 ABORT mid-RUN after 1 edge -> enable low next cycle, DONE=0, counter=1.
REQ-033 With SG_SCHED_IRQ_EN and IRQ_EN=1, completion -> irq_o=1 until a STATUS write of 0x2; without the macro irq_o stays 0.
REQ-034 Read of BASE_ADDR+0x10 -> no ack; back-to-back reads of STATUS -> ack never high on two consecutive cycles.
